// File: rtl/snn_input_loader_if.sv
// ---------------------------------------------------------------------------
// snn_input_loader_if
// Purpose : bundles the byte-stream input, ram_input_unit write port,
//           snn_core handshake and UART-transmit handoff of snn_input_loader.
// Modports:
//   slave  - the loader itself (consumes rx/done/digit, drives the rest)
//   master - the surrounding system (UART rx, snn_core, UART tx, RAM)
// Signals :
//   rx_rdy, rx_data[7:0]     byte strobe and data from the UART receiver
//   ram_addr[ADDR_W-1:0], ram_data, ram_we, ram_sel   RAM write port / owner
//   start, done, digit[3:0]  snn_core handshake and result
//   tx_start, tx_data[7:0]   UART transmitter handoff (ASCII digit)
//   busy, overrun, timeout_err  status
// ---------------------------------------------------------------------------
interface snn_input_loader_if #(
  parameter int ADDR_W = 10
);
  logic              rx_rdy;
  logic [7:0]        rx_data;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_data;
  logic              ram_we;
  logic              ram_sel;
  logic              start;
  logic              done;
  logic [3:0]        digit;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              busy;
  logic              overrun;
  logic              timeout_err;

  modport slave (
    input  rx_rdy, rx_data, done, digit,
    output ram_addr, ram_data, ram_we, ram_sel, start,
           tx_start, tx_data, busy, overrun, timeout_err
  );

  modport master (
    output rx_rdy, rx_data, done, digit,
    input  ram_addr, ram_data, ram_we, ram_sel, start,
           tx_start, tx_data, busy, overrun, timeout_err
  );
endinterface

// File: rtl/snn_input_loader.sv
// ---------------------------------------------------------------------------
// snn_input_loader
// Purpose : collects NUM_BITS/8 packed image bytes from the UART receiver,
//           unpacks each byte LSB-first into 8 single-bit RAM writes, kicks
//           snn_core with a one-cycle start, waits for done and hands the
//           result to the UART transmitter as ASCII (8'h30 + digit).
// Ports   :
//   clk    - system clock, all state on the rising edge
//   rst_n  - asynchronous active-low reset (aborts any partial image)
//   bus    - snn_input_loader_if.slave (rx byte stream, RAM write port,
//            snn_core start/done/digit, tx_start/tx_data, busy/overrun/
//            timeout_err)
// Config  : define SNN_LOADER_TIMEOUT_EN to discard a partial image after
//           TIMEOUT_CYCLES cycles without a new byte; otherwise the loader
//           waits indefinitely and timeout_err is tied low.
// ---------------------------------------------------------------------------
module snn_input_loader #(
  parameter int NUM_BITS       = 784,
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  snn_input_loader_if.slave   bus
);

  localparam int NUM_BYTES = NUM_BITS / 8;
  localparam int BCW       = ADDR_W - 3;   // byte counter width; addr = {byte, bit}

  // Reject parameter sets the address packing cannot represent.
  if ((NUM_BITS % 8) != 0 || NUM_BITS > (1 << ADDR_W) || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("snn_input_loader: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_START,
    S_WAIT_DONE,
    S_SEND
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       byte_q, byte_d;        // byte currently being unpacked
  logic [7:0]       hold_q, hold_d;        // one-entry holding register
  logic             hold_full_q, hold_full_d;
  logic [2:0]       bit_q, bit_d;
  logic [BCW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             overrun_q, overrun_d;

`ifdef SNN_LOADER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              timeout_q, timeout_d;
`endif

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    byte_d      = byte_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    bit_d       = bit_q;
    byte_cnt_d  = byte_cnt_q;
    tx_data_d   = tx_data_q;
    overrun_d   = overrun_q;
`ifdef SNN_LOADER_TIMEOUT_EN
    idle_d      = '0;
    timeout_d   = timeout_q;
`endif

    unique case (state_q)
      S_IDLE, S_LOAD: begin
        // A byte parked at the end of the previous image is served first;
        // a byte arriving while it is still parked has nowhere to go.
        if (hold_full_q) begin
          byte_d      = hold_q;
          hold_full_d = 1'b0;
          bit_d       = 3'd0;
          state_d     = S_WRITE;
          if (bus.rx_rdy) overrun_d = 1'b1;
        end else if (bus.rx_rdy) begin
          byte_d  = bus.rx_data;
          bit_d   = 3'd0;
          state_d = S_WRITE;
        end
`ifdef SNN_LOADER_TIMEOUT_EN
        // LOAD always has at least one byte of the image already written.
        if (state_q == S_LOAD && !bus.rx_rdy) begin
          if (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
            byte_cnt_d = '0;
            timeout_d  = 1'b1;
            state_d    = S_IDLE;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
`endif
      end

      S_WRITE: begin
        if (bus.rx_rdy) begin
          if (hold_full_q) begin
            overrun_d = 1'b1;
          end else begin
            hold_d      = bus.rx_data;
            hold_full_d = 1'b1;
          end
        end
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          byte_cnt_d = byte_cnt_q + BCW'(1);
          if (byte_cnt_q == BCW'(NUM_BYTES - 1)) begin
            state_d = S_START;
          end else if (hold_full_q) begin
            // Back-to-back WRITE: no LOAD gap when a byte is waiting.
            byte_d      = hold_q;
            hold_full_d = 1'b0;
          end else if (bus.rx_rdy) begin
            // Byte landing on the final bit goes straight into the next WRITE.
            byte_d      = bus.rx_data;
            hold_full_d = 1'b0;
          end else begin
            state_d = S_LOAD;
          end
        end
      end

      S_START: begin
        if (bus.rx_rdy) overrun_d = 1'b1;
        byte_cnt_d = '0;
        state_d    = S_WAIT_DONE;
      end

      S_WAIT_DONE: begin
        if (bus.rx_rdy) overrun_d = 1'b1;
        if (bus.done) begin
          // No clamp: digits above 9 map onto ':' .. '?'.
          tx_data_d = 8'h30 + {4'h0, bus.digit};
          state_d   = S_SEND;
        end
      end

      S_SEND: begin
        if (bus.rx_rdy) overrun_d = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      byte_q      <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      bit_q       <= '0;
      byte_cnt_q  <= '0;
      tx_data_q   <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      bit_q       <= bit_d;
      byte_cnt_q  <= byte_cnt_d;
      tx_data_q   <= tx_data_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef SNN_LOADER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
    end
  end
  assign bus.timeout_err = timeout_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Outputs (decoded from registered state, so reset clears them at once)
  // -------------------------------------------------------------------------
  assign bus.ram_we   = (state_q == S_WRITE);
  assign bus.ram_addr = (state_q == S_WRITE) ? {byte_cnt_q, bit_q} : '0;
  assign bus.ram_data = (state_q == S_WRITE) & byte_q[bit_q];
  assign bus.ram_sel  = (state_q == S_IDLE) || (state_q == S_LOAD) || (state_q == S_WRITE);
  assign bus.start    = (state_q == S_START);
  assign bus.tx_start = (state_q == S_SEND);
  assign bus.tx_data  = tx_data_q;
  assign bus.busy     = !((state_q == S_IDLE) || (state_q == S_LOAD));
  assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_snn_input_loader.sv
// ---------------------------------------------------------------------------
// tb_snn_input_loader
// Self-checking bench: a cycle-level behavioural model (byte queue + phase)
// predicts every output each cycle; directed image sequences pin the model
// with literal expectations; a long randomized phase follows.
// ---------------------------------------------------------------------------
module tb_snn_input_loader;
  localparam int NBITS  = 784;
  localparam int NBYTES = NBITS / 8;
  localparam int TO     = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  snn_input_loader_if #(.ADDR_W(10)) bus ();

  snn_input_loader #(
    .NUM_BITS(NBITS),
    .ADDR_W(10),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_ph;          // 0 collecting, 1 start, 2 waiting, 3 sending
  bit         m_wr;          // a byte is being written
  logic [7:0] m_cur;
  int         m_bit;
  logic [7:0] m_held[$];     // at most one parked byte
  int         m_bcnt;        // bytes of current image completed
  logic [7:0] m_tx;
  bit         m_ovr, m_terr;
  int         m_idle;

  task automatic model_reset();
    m_ph = 0; m_wr = 0; m_cur = 0; m_bit = 0; m_held.delete();
    m_bcnt = 0; m_tx = 0; m_ovr = 0; m_terr = 0; m_idle = 0;
  endtask

  task automatic model_step(input bit rx, input logic [7:0] rxd, input bit dn, input logic [3:0] dg);
    bit in_load;
    in_load = (m_ph == 0) && !m_wr && (m_bcnt > 0);
    case (m_ph)
      0: begin
        if (rx) begin
          if (m_held.size() > 0) m_ovr = 1;
          else m_held.push_back(rxd);
        end
        if (m_wr) begin
          if (m_bit == 7) begin
            m_bcnt++;
            m_wr = 0;
            if (m_bcnt == NBYTES) m_ph = 1;
            else if (m_held.size() > 0) begin
              m_cur = m_held.pop_front(); m_bit = 0; m_wr = 1;
            end
          end else m_bit++;
        end else if (m_held.size() > 0) begin
          m_cur = m_held.pop_front(); m_bit = 0; m_wr = 1;
        end
`ifdef SNN_LOADER_TIMEOUT_EN
        if (in_load && !rx) begin
          m_idle++;
          if (m_idle == TO) begin m_bcnt = 0; m_terr = 1; m_idle = 0; end
        end else m_idle = 0;
`else
        if (in_load) m_idle = 0;
`endif
      end
      1: begin if (rx) m_ovr = 1; m_bcnt = 0; m_ph = 2; end
      2: begin if (rx) m_ovr = 1; if (dn) begin m_tx = 8'h30 + {4'h0, dg}; m_ph = 3; end end
      default: begin if (rx) m_ovr = 1; m_ph = 0; end
    endcase
  endtask

  function automatic logic [25:0] exp_vec();
    logic [9:0] a;
    logic       d;
    a = m_wr ? 10'(m_bcnt * 8 + m_bit) : 10'd0;
    d = m_wr ? m_cur[m_bit] : 1'b0;
    return {m_wr, a, d, (m_ph == 0), (m_ph == 1), (m_ph == 3), m_tx,
            (m_wr || m_ph != 0), m_ovr, m_terr};
  endfunction

  function automatic logic [25:0] act_vec();
    return {bus.ram_we, bus.ram_addr, bus.ram_data, bus.ram_sel, bus.start, bus.tx_start,
            bus.tx_data, bus.busy, bus.overrun, bus.timeout_err};
  endfunction

  // ---------------- compare / monitor process ----------------
  logic tb_ram [NBITS];
  int   we_cnt = 0, start_cnt = 0, tx_cnt = 0, cyc = 0;
  bit   prev_we = 0;
  logic [9:0] prev_addr = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (rst_n) model_step(bus.rx_rdy, bus.rx_data, bus.done, bus.digit);
      #1;
      cyc++;
      check($sformatf("cycle%0d", cyc), 32'(act_vec()), 32'(exp_vec()));
      if (bus.ram_we && bus.ram_sel) begin
        tb_ram[bus.ram_addr] = bus.ram_data;
        we_cnt++;
      end
      if (bus.start) begin
        start_cnt++;
        check("start_after_last_write", {21'd0, prev_we, prev_addr}, {21'd0, 1'b1, 10'd783});
      end
      if (bus.tx_start) begin
        tx_cnt++;
        $display("image classified: tx_data=%0h overrun=%0b", bus.tx_data, bus.overrun);
      end
      prev_we   = bus.ram_we;
      prev_addr = bus.ram_addr;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; model_reset();
    bus.rx_rdy = 0; bus.done = 0;
    #1;
    check("reset_outputs", 32'(act_vec()), {6'd0, 26'b0_0000000000_0_1_0_0_00000000_0_0_0});
    repeat (3) @(negedge clk);
    rst_n = 1;
    we_cnt = 0; start_cnt = 0; tx_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    bus.rx_rdy = 1; bus.rx_data = b;
    @(negedge clk);
    bus.rx_rdy = 0;
    repeat (gap) @(negedge clk);
  endtask

  function automatic logic [7:0] ram_byte(input int base);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = tb_ram[base + k];
    return r;
  endfunction

  initial begin
    int bad;
    logic [7:0] pat;
    bus.rx_rdy = 0; bus.rx_data = 0; bus.done = 0; bus.digit = 0;
    model_reset();
    for (int k = 0; k < NBITS; k++) tb_ram[k] = 1'b0;

    // Full image of 8'hA5, then classification digit 7.
    do_reset();
    for (int n = 0; n < NBYTES; n++) send_byte(8'hA5, 9);
    repeat (3) @(negedge clk);
    check("image_we_count", we_cnt, 784);
    check("image_start_count", start_cnt, 1);
    pat = 8'hA5;
    bad = 0;
    for (int k = 0; k < NBITS; k++) if (tb_ram[k] !== pat[k % 8]) bad++;
    check("a5_pattern_errors", bad, 0);
    bus.done = 1; bus.digit = 4'd7;
    for (int i = 0; i < 50 && tx_cnt == 0; i++) @(negedge clk);
    check("tx_start_count", tx_cnt, 1);
    @(negedge clk);
    bus.done = 0;
    check("tx_data_7", bus.tx_data, 8'h37);
    check("ram_sel_after_send", bus.ram_sel, 1);
    check("busy_after_send", bus.busy, 0);
    $display("txn image_a5: we=%0d start=%0d tx=%0d", we_cnt, start_cnt, tx_cnt);

    // Single byte 8'h01: write begins the cycle after rx_rdy.
    do_reset();
    @(negedge clk);
    bus.rx_rdy = 1; bus.rx_data = 8'h01;
    @(posedge clk); #1;
    check("first_we_latency", {bus.ram_we, bus.ram_addr, bus.ram_data, bus.ram_sel}, 13'b1_0000000000_1_1);
    @(negedge clk);
    bus.rx_rdy = 0;
    repeat (10) @(negedge clk);
    check("byte01_addr0_7", ram_byte(0), 8'h01);
    $display("txn byte01: ram[7:0]=%0h", ram_byte(0));

    // rx_rdy on cycles 0,2,4: third byte meets a full holding register.
    do_reset();
    @(negedge clk); bus.rx_rdy = 1; bus.rx_data = 8'h3C;
    @(negedge clk); bus.rx_rdy = 0;
    @(negedge clk); bus.rx_rdy = 1; bus.rx_data = 8'hC3;
    @(negedge clk); bus.rx_rdy = 0;
    @(negedge clk); bus.rx_rdy = 1; bus.rx_data = 8'hFF;
    @(negedge clk); bus.rx_rdy = 0;
    repeat (20) @(negedge clk);
    check("overrun_set", bus.overrun, 1);
    check("overrun_we_count", we_cnt, 16);
    check("overrun_byte0", ram_byte(0), 8'h3C);
    check("overrun_byte1", ram_byte(8), 8'hC3);
    $display("txn overrun: we=%0d overrun=%0b", we_cnt, bus.overrun);

    // Reset after 40 bytes, then a complete image from address 0.
    do_reset();
    for (int n = 0; n < 40; n++) send_byte(8'h5A, 9);
    check("partial_we_count", we_cnt, 320);
    do_reset();
    for (int n = 0; n < NBYTES; n++) send_byte(8'h96, 9);
    repeat (3) @(negedge clk);
    check("reload_we_count", we_cnt, 784);
    check("reload_start_count", start_cnt, 1);
    check("reload_byte0", ram_byte(0), 8'h96);
    $display("txn reset_reload: we=%0d start=%0d", we_cnt, start_cnt);

`ifdef SNN_LOADER_TIMEOUT_EN
    // Silence after 10 bytes discards the partial image.
    do_reset();
    for (int n = 0; n < 10; n++) send_byte(8'h11, 9);
    repeat (TO + 20) @(negedge clk);
    check("timeout_err_set", bus.timeout_err, 1);
    send_byte(8'h5A, 9);
    check("after_timeout_byte0", ram_byte(0), 8'h5A);
    $display("txn timeout: timeout_err=%0b", bus.timeout_err);
`endif

    // Randomized traffic at several byte densities with random done/digit.
    do_reset();
    for (int seg = 0; seg < 4; seg++) begin
      int dens;
      dens = (seg == 0) ? 9 : (seg == 1) ? 3 : (seg == 2) ? 14 : 6;
      for (int c = 0; c < 4000; c++) begin
        @(negedge clk);
        bus.rx_rdy  = ($urandom_range(0, dens) == 0);
        bus.rx_data = 8'($urandom);
        bus.done    = ($urandom_range(0, 15) == 0);
        bus.digit   = 4'($urandom_range(0, 15));
      end
    end
    @(negedge clk);
    bus.rx_rdy = 0; bus.done = 0;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
